// File: rtl/descrambler_multilane_pkg.sv
// Shared constants and the LFSR step helper for the multi-lane descrambler.
package descrambler_multilane_pkg;

  localparam logic [15:0] TAPS16    = 16'h0039;
  localparam logic [22:0] TAPS23    = 23'h210125;
  localparam logic [15:0] SEED16    = 16'hFFFF;
  localparam logic [7:0]  SYM_COM   = 8'hBC;
  localparam logic [7:0]  SYM_SKP8  = 8'h1C;
  localparam logic [7:0]  SYM_SKP   = 8'hAA;
  localparam logic [7:0]  SYM_EIEOS = 8'h00;

  typedef enum logic [1:0] {
    HDR_BAD0 = 2'b00,
    HDR_DATA = 2'b01,
    HDR_OS   = 2'b10,
    HDR_BAD3 = 2'b11
  } sync_hdr_e;

  typedef struct packed {
    logic [22:0] state;
    logic [7:0]  key;
  } lfsr_step_t;

  // Eight Galois shifts; each key bit is the LFSR MSB before its shift.
  function automatic lfsr_step_t lfsr_advance8(input logic [22:0] s, input logic gen3);
    lfsr_step_t r;
    logic fb;
    r.state = s;
    r.key   = '0;
    for (int i = 0; i < 8; i++) begin
      if (gen3) begin
        fb        = r.state[22];
        r.key[i]  = fb;
        r.state   = {r.state[21:0], 1'b0} ^ (fb ? TAPS23 : 23'd0);
      end else begin
        fb        = r.state[15];
        r.key[i]  = fb;
        r.state   = {7'd0, r.state[14:0], 1'b0} ^ (fb ? {7'd0, TAPS16} : 23'd0);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/descrambler_multilane_lane.sv
// One descrambler lane: LFSR, block symbol counter and SYMS-wide unrolled advance.
module descrambler_lane
  import descrambler_multilane_pkg::*;
#(
  parameter int SYMS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                gen3_en,
  input  logic                bypass,
  input  logic                load_seed,
  input  logic [22:0]         seed,
  input  logic                in_valid,
  input  logic [SYMS*8-1:0]   in_data,
  input  logic [SYMS-1:0]     in_datak,
  input  logic [1:0]          in_sync_hdr,
  input  logic                in_block_start,
  output logic [SYMS*8-1:0]   out_data,
  output logic [SYMS-1:0]     out_datak,
  output logic [1:0]          out_sync_hdr,
  output logic                out_block_start
);

  localparam logic [22:0] SEED_G1 = {7'd0, SEED16};

  logic [22:0]       lfsr_q, lfsr_d, mode_seed, st;
  logic [3:0]        cnt_q, cnt_d, pos;
  logic              skp_q, skp_d, eieos_q, eieos_d, skp, eieos;
  logic [SYMS*8-1:0] data_d;
  logic [7:0]        sym, out_sym;
  lfsr_step_t        step;

  // Walk the beat symbol by symbol, starting from the seed on a reload cycle.
  always_comb begin
    lfsr_d    = lfsr_q;
    cnt_d     = cnt_q;
    skp_d     = skp_q;
    eieos_d   = eieos_q;
    data_d    = in_data;
    sym       = '0;
    out_sym   = '0;
    mode_seed = gen3_en ? seed : SEED_G1;
    st        = load_seed ? mode_seed : lfsr_q;
    pos       = (load_seed || in_block_start) ? 4'd0 : cnt_q;
    skp       = in_block_start ? (in_data[7:0] == SYM_SKP)   : skp_q;
    eieos     = in_block_start ? (in_data[7:0] == SYM_EIEOS) : eieos_q;
    step      = '0;

    for (int s = 0; s < SYMS; s++) begin
      sym     = in_data[s*8 +: 8];
      out_sym = sym;
      step    = lfsr_advance8(st, gen3_en);
      if (gen3_en) begin
        case (sync_hdr_e'(in_sync_hdr))
          HDR_DATA: begin
            out_sym = sym ^ step.key;
            st      = step.state;
          end
          HDR_OS: begin
            if (!skp) st = step.state;
            if (eieos && pos == 4'd15) st = mode_seed;
          end
          default: st = step.state;
        endcase
      end else begin
        if (in_datak[s] && sym == SYM_COM) begin
          st = mode_seed;
        end else if (in_datak[s] && sym == SYM_SKP8) begin
          st = st;
        end else if (in_datak[s]) begin
          st = step.state;
        end else begin
          out_sym = sym ^ step.key;
          st      = step.state;
        end
      end
      if (!bypass) data_d[s*8 +: 8] = out_sym;
      pos = pos + 4'd1;
    end

    if (in_valid) begin
      lfsr_d  = st;
      cnt_d   = gen3_en ? pos : 4'd0;
      skp_d   = skp;
      eieos_d = eieos;
    end else if (load_seed) begin
      lfsr_d  = mode_seed;
      cnt_d   = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q          <= SEED_G1;
      cnt_q           <= 4'd0;
      skp_q           <= 1'b0;
      eieos_q         <= 1'b0;
      out_data        <= '0;
      out_datak       <= '0;
      out_sync_hdr    <= '0;
      out_block_start <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      skp_q   <= skp_d;
      eieos_q <= eieos_d;
      if (in_valid) begin
        out_data        <= data_d;
        out_datak       <= in_datak;
        out_sync_hdr    <= in_sync_hdr;
        out_block_start <= in_block_start;
      end
    end
  end

endmodule

// File: rtl/descrambler_multilane.sv
// Multi-lane PCIe descrambler: shared mode tracking plus LANES independent lanes.
module descrambler_multilane
  import descrambler_multilane_pkg::*;
#(
  parameter int LANES = 4,
  parameter int SYMS  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    gen3_en,
  input  logic                    bypass,
  input  logic [LANES*23-1:0]     seed,
  input  logic                    in_valid,
  input  logic [LANES*SYMS*8-1:0] in_data,
  input  logic [LANES*SYMS-1:0]   in_datak,
  input  logic [LANES*2-1:0]      in_sync_hdr,
  input  logic [LANES-1:0]        in_block_start,
  output logic                    out_valid,
  output logic [LANES*SYMS*8-1:0] out_data,
  output logic [LANES*SYMS-1:0]   out_datak,
  output logic [LANES*2-1:0]      out_sync_hdr,
  output logic [LANES-1:0]        out_block_start
);

  logic gen3_q, restart_q, load_seed;

  // The first edge after reset and any mode flip both restart every lane from its seed.
  assign load_seed = restart_q | (gen3_en != gen3_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gen3_q    <= 1'b0;
      restart_q <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      gen3_q    <= gen3_en;
      restart_q <= 1'b0;
      out_valid <= in_valid;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    descrambler_lane #(.SYMS(SYMS)) u_lane (
      .clk             (clk),
      .reset           (reset),
      .gen3_en         (gen3_en),
      .bypass          (bypass),
      .load_seed       (load_seed),
      .seed            (seed[l*23 +: 23]),
      .in_valid        (in_valid),
      .in_data         (in_data[l*SYMS*8 +: SYMS*8]),
      .in_datak        (in_datak[l*SYMS +: SYMS]),
      .in_sync_hdr     (in_sync_hdr[l*2 +: 2]),
      .in_block_start  (in_block_start[l]),
      .out_data        (out_data[l*SYMS*8 +: SYMS*8]),
      .out_datak       (out_datak[l*SYMS +: SYMS]),
      .out_sync_hdr    (out_sync_hdr[l*2 +: 2]),
      .out_block_start (out_block_start[l])
    );
  end

endmodule

// File: doc/descrambler_multilane.md
DESCRAMBLER_MULTILANE -- requirements
Module: descrambler_multilane

Interface
REQ-001 The block SHALL have parameter LANES, default 4, number of independent lanes (1, 2, 4, 8, 16).
REQ-002 The block SHALL have parameter SYMS, default 4, symbols per lane per clock (1, 2, 4).
REQ-003 The block SHALL have port clk, input, 1, clock.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port gen3_en, input, 1: 0 = 8b/10b mode, 1 = 128b/130b mode.
REQ-006 The block SHALL have port bypass, input, 1: pass data unmodified while LFSRs still track.
REQ-007 The block SHALL have port seed, input, LANES*23, per-lane 128b/130b seed.
REQ-008 The block SHALL have port in_valid, input, 1, input beat qualifier.
REQ-009 The block SHALL have port in_data, input, LANES*SYMS*8, lane-major symbols, symbol 0 in LSBs.
REQ-010 The block SHALL have port in_datak, input, LANES*SYMS, K flag per symbol (8b/10b mode only).
REQ-011 The block SHALL have port in_sync_hdr, input, LANES*2: 2'b01 data block, 2'b10 ordered set.
REQ-012 The block SHALL have port in_block_start, input, LANES, first beat of a 130b block.
REQ-013 The block SHALL have ports out_valid, out_data, out_datak, out_sync_hdr and out_block_start, outputs, widths matching their inputs, registered results.

Function
REQ-014 All outputs SHALL be registered with exactly 1 clk latency from an in_valid beat; out_valid = in_valid delayed 1 cycle.
REQ-015 With in_valid=0, LFSR state, symbol counters and the out_* data fields SHALL hold; out_valid SHALL be 0.
REQ-016 In 8b/10b mode, each lane SHALL use LFSR G(X)=X^16+X^5+X^4+X^3+1 with seed 16'hFFFF, advancing 8 shifts per symbol.
REQ-017 In 8b/10b mode: a K28.5 (8'hBC, K=1) symbol SHALL pass unmodified and reload the seed for the next symbol in the same or next beat.
REQ-018 In 8b/10b mode: a K28.0 (8'h1C, K=1) symbol SHALL pass unmodified without advancing the LFSR.
REQ-019 In 8b/10b mode: other K symbols SHALL pass unmodified and advance the LFSR; D symbols SHALL be XORed with the LFSR byte, then advance it.
REQ-020 In 128b/130b mode, each lane SHALL use LFSR G(X)=X^23+X^21+X^16+X^8+X^5+X^2+1, loaded from its seed slice.
REQ-021 In 128b/130b mode: a per-lane 4-bit symbol counter SHALL clear on in_block_start and increment by SYMS per beat, wrapping at 16.
REQ-022 In 128b/130b mode: data blocks (2'b01) SHALL have all 16 symbols descrambled; in_datak SHALL be ignored.
REQ-023 In 128b/130b mode: ordered-set blocks (2'b10) SHALL pass unmodified.
REQ-024 In 128b/130b mode: an ordered set whose symbol 0 is 8'hAA (SKP) SHALL not advance the LFSR; other ordered sets SHALL advance it.
REQ-025 In 128b/130b mode: an ordered set whose symbol 0 is 8'h00 (EIEOS) SHALL reload the seed after its symbol 15.
REQ-026 An invalid sync header (2'b00/2'b11) SHALL pass data unmodified and advance the LFSR as for data.
REQ-027 Any change of gen3_en, sampled per cycle, SHALL reload all LFSRs with their mode seed and clear all counters on the next edge.
REQ-028 Lanes SHALL be fully independent; out_datak, out_sync_hdr and out_block_start SHALL be the delayed inputs.

Reset
REQ-029 While reset=0: all LFSRs SHALL hold their seed (16'hFFFF, or seed slice in 128b/130b mode), counters SHALL be 0, all outputs SHALL be 0.
REQ-030 Assertion of reset mid-beat SHALL discard the beat; the first in_valid beat after release SHALL use the seed.

Structure
REQ-031 A shared package SHALL hold both polynomial tap constants, the 16'hFFFF seed, symbol codes 8'hBC/8'h1C/8'hAA/8'h00, and sync-header encodings.
REQ-032 One sub-module, descrambler_lane, SHALL implement one lane (LFSR, counter, SYMS-symbol unrolled advance); the top SHALL instantiate it LANES times.

Verification
REQ-033 A bench SHALL cover: 8b/10b mode, SYMS=4, beat {K BC, D00, D00, D00} then {D00 x4} -> out bytes BC, FF, 17, C0 then 14, B2, E7, 02.
REQ-034 A bench SHALL cover: 8b/10b mode, K1C inserted between D00 symbols -> 8'h1C passes and the keystream resumes without skipping bytes.
REQ-035 A bench SHALL cover: 128b/130b mode, 2'b01 data block of all-zero data on 4 lanes with distinct seeds -> each lane outputs its own keystream matching the reference model.
REQ-036 A bench SHALL cover: 128b/130b mode, SKP OS (8'hAA) between two data blocks -> the second block's keystream continues exactly where the first ended.
REQ-037 A bench SHALL cover: 128b/130b mode, EIEOS then data block -> the data block is descrambled from the seed.
REQ-038 A bench SHALL cover: reset asserted mid-block and gen3_en toggled mid-stream -> outputs are 0 during reset, and the next beat is descrambled from the seed.
